mips_input_ctrl: RTL
====================

// Module: mips_input_ctrl
// PURPOSE
//  Board-side input conditioner sitting directly upstream of the MIPS top level.
//  Synchronises raw switches/buttons, debounces the load button and emits a single
//  one-cycle port_en strobe per press, with port_sel/user_input held stable around it.
//  Also provides a synchronised level port_rst for clearing the datapath input ports.
// PARAMETERS
//  SW_W       10      number of raw data switches; zero-extended into user_input[31:0]
//  DB_CYCLES  500000  debounce length in clk cycles (10 ms @ 50 MHz); legal 1..2^CNT_W-1
//  CNT_W      20      debounce counter width
// PORTS
//  clk          in   1      system clock, all logic rising-edge
//  rst          in   1      asynchronous, active-high reset
//  raw_sw       in   SW_W   raw data switches (asynchronous)
//  raw_sel      in   1      raw port-select switch (asynchronous)
//  raw_btn_load in   1      raw load pushbutton, active-high, bouncy
//  raw_btn_clr  in   1      raw port-clear pushbutton, active-high
//  port_sel     out  1      captured port select (0 = in0, 1 = in1)
//  port_en      out  1      one-cycle load strobe
//  user_input   out  32     captured data {(32-SW_W)'b0, sw}
//  port_rst     out  1      synchronised clear level
//  busy         out  1      high whenever FSM is not IDLE
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (clk, rst). On rst: all sync flops 0,
//    FSM=IDLE, cnt=0, port_sel=0, port_en=0, user_input=0, port_rst=0, busy=0.
//  - All raw inputs pass through 2-flop synchronisers; *_s denotes the 2nd-stage value.
//    port_rst = btn_clr_s (registered, no debounce); independent of FSM; priority of
//    port_rst over port_en is resolved downstream.
//  - FSM states: IDLE, DB_PRESS, FIRE, WAIT_REL, DB_REL.
//    IDLE:     btn_load_s=1 -> DB_PRESS, cnt<=1; else stay, cnt<=0.
//    DB_PRESS: btn_load_s=0 -> IDLE, cnt<=0 (bounce restarts debounce);
//              btn_load_s=1 & cnt==DB_CYCLES -> FIRE; else cnt<=cnt+1.
//    FIRE:     exactly one cycle -> WAIT_REL, cnt<=0.
//    WAIT_REL: btn_load_s=0 -> DB_REL, cnt<=1; else stay (held button never re-fires).
//    DB_REL:   btn_load_s=1 -> WAIT_REL, cnt<=0; btn_load_s=0 & cnt==DB_CYCLES -> IDLE;
//              else cnt<=cnt+1.
//  - port_en = (state==FIRE), decoded from the state register (glitch-free, registered timing).
//  - On the edge entering FIRE: user_input<={0,sw_s}, port_sel<=sel_s. Both hold until the next
//    FIRE entry, so they are stable the cycle before, during and after port_en.
//  - Latency: btn_load_s must be sampled high on DB_CYCLES+1 consecutive edges; port_en rises
//    on the next edge. Raw press to port_en = 2 (sync) + DB_CYCLES + 1 cycles.
//  - Switch changes coinciding with the FIRE-entry edge: the value sampled from sw_s at that
//    edge is captured; later changes are ignored until the next press.
//  - Counter never wraps: it is only compared for equality with DB_CYCLES and is cleared on
//    every exit path. DB_CYCLES=1 is legal (two consecutive high samples).
//  - rst mid-operation (any state): immediate return to IDLE; a pending strobe is dropped;
//    a button still held after rst release is treated as a fresh press.
//  - busy = (state != IDLE).
// TESTING  (bench uses DB_CYCLES=4, SW_W=10)
//  1. raw_sw=10'h2A5, raw_sel=1, clean press held 20 cycles -> exactly one port_en pulse,
//     2+4+1 cycles after the press; user_input=32'h000002A5, port_sel=1 held after release.
//  2. Bounce: high 3 cycles, low 1, high 3, low 1, then high 10 -> single port_en, timed from
//     the start of the final stable high run; no pulse during the bounce.
//  3. Release bounce: after fire, drop for 2 cycles then rise for 2 -> no 2nd port_en; a new
//     clean press after a stable 5-cycle release fires again with the new raw_sw value.
//  4. Change raw_sw 10'h001->10'h3FF while the button is held after FIRE -> user_input stays
//     32'h00000001 until the next press.
//  5. Assert rst in DB_PRESS and again in FIRE -> outputs 0 immediately, no port_en pulse,
//     busy=0; button still held after rst release -> one pulse after a full debounce.
//  6. raw_btn_clr high for 3 cycles -> port_rst high for 3 cycles, 2 cycles delayed;
//     FSM state and user_input unaffected.

Source files
------------

// File: rtl/mips_input_ctrl.sv
// mips_input_ctrl: synchronises board switches/buttons, debounces the load button into a
// single port_en strobe with captured port_sel/user_input, and passes through a clear level.
module mips_input_ctrl #(
  parameter int SW_W      = 10,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] raw_sw,
  input  logic            raw_sel,
  input  logic            raw_btn_load,
  input  logic            raw_btn_clr,
  output logic            port_sel,
  output logic            port_en,
  output logic [31:0]     user_input,
  output logic            port_rst,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, DB_PRESS, FIRE, WAIT_REL, DB_REL} state_t;
  localparam logic [CNT_W-1:0] DB = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SW_W-1:0] sw_m, sw_s;
  logic sel_m, sel_s, load_m, load_s, clr_m, clr_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_m   <= '0;
      sw_s   <= '0;
      sel_m  <= 1'b0;
      sel_s  <= 1'b0;
      load_m <= 1'b0;
      load_s <= 1'b0;
      clr_m  <= 1'b0;
      clr_s  <= 1'b0;
    end else begin
      sw_m   <= raw_sw;
      sw_s   <= sw_m;
      sel_m  <= raw_sel;
      sel_s  <= sel_m;
      load_m <= raw_btn_load;
      load_s <= load_m;
      clr_m  <= raw_btn_clr;
      clr_s  <= clr_m;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // the counter is cleared on every exit path, so it only ever counts up to DB
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        state_n = load_s ? DB_PRESS : IDLE;
        cnt_n   = load_s ? ONE : '0;
      end
      DB_PRESS:
        if (!load_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB) state_n = FIRE;
        else cnt_n = cnt + ONE;
      FIRE: begin
        state_n = WAIT_REL;
        cnt_n   = '0;
      end
      WAIT_REL:
        if (!load_s) begin
          state_n = DB_REL;
          cnt_n   = ONE;
        end
      DB_REL:
        if (load_s) begin
          state_n = WAIT_REL;
          cnt_n   = '0;
        end else if (cnt == DB) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + ONE;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // FIRE is only reachable from DB_PRESS, so state_n==FIRE marks the entry edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      user_input <= '0;
      port_sel   <= 1'b0;
    end else if (state_n == FIRE) begin
      user_input <= 32'(sw_s);
      port_sel   <= sel_s;
    end
  assign port_en  = (state == FIRE);
  assign busy     = (state != IDLE);
  assign port_rst = clr_s;
endmodule
